adc_capture: RTL and testbench
==============================

ADC_CAPTURE -- requirements
Module: adc_capture

Interface
REQ-001 SHALL have parameter DATA_W, default 12, meaning ADC sample width in bits (1..16).
REQ-002 SHALL have parameter CLK_DIV, default 2, meaning sys_clk cycles per ADC clock period; even, >=2.
REQ-003 SHALL have parameter PIPE_LAT, default 7, meaning ADC pipeline latency in ADC clocks; samples discarded after enable (0..255).
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, meaning output FIFO entries; power of 2, >=2.
REQ-005 SHALL have port sys_clk  in  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port en  in  1  capture enable; level.
REQ-008 SHALL have port adc_clk  out  1  registered ADC sample clock.
REQ-009 SHALL have port adc_d  in  DATA_W  ADC parallel data bus.
REQ-010 SHALL have port m_data  out  DATA_W  FIFO head sample.
REQ-011 SHALL have port m_valid  out  1  FIFO non-empty.
REQ-012 SHALL have port m_ready  in  1  consumer accepts m_data.
REQ-013 SHALL have port level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-014 SHALL have port ovf  out  1  sticky overflow flag.
REQ-015 SHALL have port ovf_clr  in  1  clears ovf.

Function
REQ-016 Divider counter div_cnt SHALL count 0..CLK_DIV-1 and wrap while en=1; held at 0 while en=0.
REQ-017 adc_clk SHALL be 1 when div_cnt < CLK_DIV/2 and en=1, else 0; registered, no combinational path from en.
REQ-018 A sample point SHALL occur on the sys_clk edge where div_cnt wraps CLK_DIV-1 -> 0 (adc_clk rising); adc_d is registered at that edge.
REQ-019 A discard counter SHALL reset to 0 while en=0 and increment per sample point until PIPE_LAT; sample points with counter < PIPE_LAT SHALL NOT be pushed.
REQ-020 Each non-discarded sample SHALL be pushed into the FIFO one sys_clk after its sample point.
REQ-021 m_data/m_valid SHALL be show-ahead: m_data equals oldest entry whenever m_valid=1; m_data is don't-care when m_valid=0.
REQ-022 A pop SHALL occur on an edge with m_valid=1 and m_ready=1; m_data SHALL hold stable while m_valid=1 and m_ready=0.
REQ-023 Push on full FIFO without simultaneous pop SHALL drop the sample, leave contents unchanged, and set ovf.
REQ-024 Push and pop on the same edge SHALL both take effect, including when full (no ovf) and level unchanged; pop on empty SHALL be ignored.
REQ-025 Read/write pointers SHALL wrap modulo FIFO_DEPTH; level SHALL be exact 0..FIFO_DEPTH.
REQ-026 ovf_clr=1 SHALL clear ovf; if an overflow occurs on the same edge, set SHALL win.
REQ-027 en falling SHALL stop adc_clk and new pushes within one cycle; FIFO contents SHALL remain readable.

Reset
REQ-028 rst_n=0 on a sys_clk edge SHALL set adc_clk=0, div_cnt=0, discard counter=0, FIFO empty (level=0, m_valid=0), ovf=0, captured sample=0, regardless of en or mid-transfer state.
REQ-029 After rst_n deasserts with en=1, the first sample point SHALL occur CLK_DIV cycles later and the PIPE_LAT discard SHALL restart.

Configuration
REQ-030 Macro ADC_CAPTURE_TWOS_EN defined: captured sample SHALL be converted from offset binary to two's complement by inverting bit DATA_W-1 before the FIFO push.
REQ-031 Macro ADC_CAPTURE_TWOS_EN undefined: samples SHALL pass to the FIFO unmodified (offset binary).

Verification
REQ-032 Reset then en=1, CLK_DIV=4: adc_clk = 1,1,0,0 repeating from first cycle; sample points every 4 cycles.
REQ-033 PIPE_LAT=7, adc_d ramp 0,1,2...: first m_data=7 (value at 8th sample point), subsequent 8,9,... with no gaps while m_ready=1.
REQ-034 m_ready=0, FIFO_DEPTH=16, 17 post-discard samples: level=16, ovf=1, m_data = first sample; ovf_clr pulse -> ovf=0.
REQ-035 FIFO full with m_ready=1 continuously: push+pop same edge -> level stays 16, ovf stays 0, output order preserved.
REQ-036 Macro defined, adc_d=12'h000 / 12'hFFF / 12'h800 -> m_data 12'h800 / 12'h7FF / 12'h000; undefined -> unchanged.
REQ-037 rst_n=0 mid-capture with level=5: next cycle level=0, m_valid=0, adc_clk=0, ovf=0.

Source files
------------

// File: rtl/adc_capture.sv
// ADC capture: divides sys_clk into a registered adc_clk, drops PIPE_LAT warm-up samples, and queues samples in a show-ahead FIFO.
// Optional ADC_CAPTURE_TWOS_EN: flip the sample MSB (offset binary -> two's complement) before the FIFO push.
module adc_capture #(
    parameter int DATA_W     = 12,
    parameter int CLK_DIV    = 2,
    parameter int PIPE_LAT   = 7,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          sys_clk,
    input  logic                          rst_n,
    input  logic                          en,
    output logic                          adc_clk,
    input  logic [DATA_W-1:0]             adc_d,
    output logic [DATA_W-1:0]             m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          ovf,
    input  logic                          ovf_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]     DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]     DIV_HALF   = CW'(CLK_DIV / 2);
    localparam logic [7:0]        PIPE_LAT_C = 8'(PIPE_LAT);
    localparam logic [AW:0]       DEPTH_C    = (AW+1)'(FIFO_DEPTH);
    localparam logic [DATA_W-1:0] MSB_MASK   = DATA_W'(1) << (DATA_W - 1);

    logic [CW-1:0]     div_cnt_q, div_cnt_d;
    logic              adc_clk_q, adc_clk_d;
    logic [7:0]        disc_q, disc_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic              push_q, push_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q, level_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];

    logic              sample_pt;
    logic              full;
    logic              pop;
    logic              wr;
    logic [DATA_W-1:0] push_dat;

    always_comb begin
        sample_pt = en && (div_cnt_q == DIV_LAST);

        div_cnt_d = '0;
        if (en) begin
            div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
        end
        adc_clk_d = en && (div_cnt_q < DIV_HALF);

        // Warm-up counter saturates at PIPE_LAT so it never wraps.
        disc_d = disc_q;
        if (!en) begin
            disc_d = '0;
        end else if (sample_pt && (disc_q < PIPE_LAT_C)) begin
            disc_d = disc_q + 1'b1;
        end

        sample_d = sample_pt ? adc_d : sample_q;
        push_d   = sample_pt && (disc_q >= PIPE_LAT_C);

`ifdef ADC_CAPTURE_TWOS_EN
        push_dat = sample_q ^ MSB_MASK;
`else
        push_dat = sample_q;
`endif

        full = (level_q == DEPTH_C);
        pop  = (level_q != '0) && m_ready;
        // A pop on the same edge frees the slot, so a full FIFO still accepts.
        wr   = push_q && (!full || pop);

        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (push_q && full && !pop) begin
            ovf_d = 1'b1;
        end

        mem_d = mem_q;
        if (wr) begin
            mem_d[wr_ptr_q] = push_dat;
        end
        wr_ptr_d = wr  ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q + (AW+1)'(wr) - (AW+1)'(pop);
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            adc_clk_q <= 1'b0;
            disc_q    <= '0;
            sample_q  <= '0;
            push_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            ovf_q     <= 1'b0;
            mem_q     <= '{default: '0};
        end else begin
            div_cnt_q <= div_cnt_d;
            adc_clk_q <= adc_clk_d;
            disc_q    <= disc_d;
            sample_q  <= sample_d;
            push_q    <= push_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
            mem_q     <= mem_d;
        end
    end

    assign adc_clk = adc_clk_q;
    assign m_data  = mem_q[rd_ptr_q];
    assign m_valid = (level_q != '0);
    assign level   = level_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_adc_capture.sv
// Directed bench for adc_capture with CLK_DIV=4, PIPE_LAT=7, FIFO_DEPTH=16.
module tb_adc_capture;

    logic        sys_clk;
    logic        rst_n;
    logic        en;
    logic        adc_clk;
    logic [11:0] adc_d;
    logic [11:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [4:0]  level;
    logic        ovf;
    logic        ovf_clr;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int mode = 0;

    adc_capture #(
        .DATA_W    (12),
        .CLK_DIV   (4),
        .PIPE_LAT  (7),
        .FIFO_DEPTH(16)
    ) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .en      (en),
        .adc_clk (adc_clk),
        .adc_d   (adc_d),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .level   (level),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_cnt);
        end
    endtask

    function automatic logic [11:0] stim(input int k);
        logic [31:0] kv;
        kv = k;
        if (mode == 0) return kv[11:0];
        case (k)
            7:       return 12'h000;
            8:       return 12'hFFF;
            9:       return 12'h800;
            default: return 12'h5A5;
        endcase
    endfunction

    function automatic logic [31:0] conv(input logic [11:0] v);
`ifdef ADC_CAPTURE_TWOS_EN
        return {20'h0, v ^ 12'h800};
`else
        return {20'h0, v};
`endif
    endfunction

    // adc_d for the next edge is the ramp index of that edge's ADC period.
    task automatic step();
        adc_d = stim(edge_cnt / 4);
        @(negedge sys_clk);
        edge_cnt++;
    endtask

    task automatic run_to(input int n);
        while (edge_cnt < n) step();
    endtask

    initial begin
        logic [31:0] exp_v;
        rst_n   = 1'b0;
        en      = 1'b0;
        m_ready = 1'b0;
        ovf_clr = 1'b0;
        adc_d   = '0;
        repeat (3) @(negedge sys_clk);
        chk("rst_adc_clk", adc_clk, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_level",   level,   0);
        chk("rst_ovf",     ovf,     0);

        // Divider pattern and ramp with discard
        rst_n = 1'b1;
        en    = 1'b1;
        m_ready = 1'b1;
        edge_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("adc_clk_pat", adc_clk, ((edge_cnt - 1) % 4) < 2 ? 1 : 0);
        end
        run_to(32);
        chk("discard_no_valid", m_valid, 0);
        for (int k = 7; k < 12; k++) begin
            run_to(4 * (k + 1) + 1);
            chk("ramp_valid", m_valid, 1);
            chk("ramp_data",  m_data,  conv(12'(k)));
            chk("ramp_level", level,   1);
            if (k < 11) begin
                step();
                chk("ramp_drained", level, 0);
            end
        end

        // Overflow with consumer stalled; sample 11 stays at the head
        m_ready = 1'b0;
        run_to(109);
        chk("full_level", level, 16);
        chk("full_no_ovf", ovf, 0);
        run_to(113);
        chk("ovf_level", level, 16);
        chk("ovf_set",   ovf,   1);
        chk("ovf_head",  m_data, conv(12'd11));
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr", ovf, 0);

        // Push and pop together while full
        run_to(116);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("pp_level", level, 16);
        chk("pp_ovf",   ovf,   0);
        chk("pp_head",  m_data, conv(12'd12));

        // Overflow and clear on the same edge: set wins
        run_to(120);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_set_wins", ovf, 1);

        en = 1'b0;
        step();
        chk("en_off_adc_clk", adc_clk, 0);
        chk("en_off_level",   level,   16);
        for (int i = 0; i < 16; i++) begin
            exp_v = (i < 15) ? conv(12'(12 + i)) : conv(12'd28);
            chk("drain_data", m_data, exp_v);
            m_ready = 1'b1;
            step();
        end
        chk("drain_level", level, 0);
        chk("drain_valid", m_valid, 0);
        step();
        chk("pop_empty_level", level, 0);

        // Re-enable, fill to 5, then reset mid-capture
        m_ready = 1'b0;
        en = 1'b1;
        edge_cnt = 0;
        run_to(33);
        chk("reen_first", m_data, conv(12'd7));
        run_to(49);
        chk("mid_level", level, 5);
        rst_n = 1'b0;
        step();
        chk("mid_rst_level",   level,   0);
        chk("mid_rst_valid",   m_valid, 0);
        chk("mid_rst_adc_clk", adc_clk, 0);
        chk("mid_rst_ovf",     ovf,     0);

        // Offset-binary / two's complement vectors
        mode = 1;
        rst_n = 1'b1;
        edge_cnt = 0;
        run_to(41);
        chk("twos_level", level, 3);
        chk("twos_0", m_data, conv(12'h000));
        m_ready = 1'b1;
        step();
        chk("twos_1", m_data, conv(12'hFFF));
        step();
        chk("twos_2", m_data, conv(12'h800));
        step();
        chk("twos_empty", m_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
